// File: rtl/free_list_pkg.sv
// Shared sizing, types and helpers for the physical-register free list.
package free_list_pkg;

    localparam int unsigned PHY_REGS    = 64;
    localparam int unsigned ARCH_REGS   = 32;
    localparam int unsigned FL_DEPTH    = PHY_REGS - ARCH_REGS;
    localparam int unsigned PHY_REG_SEL = $clog2(PHY_REGS);
    localparam int unsigned REG_SEL     = $clog2(ARCH_REGS);
    localparam int unsigned FL_IDX_W    = $clog2(FL_DEPTH);
    localparam int unsigned FL_PTR_W    = FL_IDX_W + 1;
    localparam int unsigned FL_CNT_W    = $clog2(FL_DEPTH + 1);

    typedef logic [PHY_REG_SEL-1:0] tag_t;
    typedef logic [FL_IDX_W-1:0]    idx_t;
    typedef logic [FL_PTR_W-1:0]    ptr_t;
    typedef logic [FL_CNT_W-1:0]    cnt_t;

    // Ring index is the pointer without its wrap bit.
    function automatic idx_t ptr_idx(input ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

    function automatic logic [1:0] pair_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/free_list_storage.sv
// Tag ring for the free list: two async read ports, two write ports,
// reset-loaded with the tags not mapped to architectural registers.
module free_list_storage
    import free_list_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FL_IDX_W-1:0]    raddr_0_i,
    input  logic [FL_IDX_W-1:0]    raddr_1_i,
    output logic [PHY_REG_SEL-1:0] rdata_0_o,
    output logic [PHY_REG_SEL-1:0] rdata_1_o,
    input  logic                   we_0_i,
    input  logic [FL_IDX_W-1:0]    waddr_0_i,
    input  logic [PHY_REG_SEL-1:0] wdata_0_i,
    input  logic                   we_1_i,
    input  logic [FL_IDX_W-1:0]    waddr_1_i,
    input  logic [PHY_REG_SEL-1:0] wdata_1_i
);

    tag_t ring_q [FL_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                ring_q[i] <= tag_t'(ARCH_REGS + i);
            end
        end else begin
            if (we_0_i) ring_q[waddr_0_i] <= wdata_0_i;
            if (we_1_i) ring_q[waddr_1_i] <= wdata_1_i;
        end
    end

    assign rdata_0_o = ring_q[raddr_0_i];
    assign rdata_1_o = ring_q[raddr_1_i];

endmodule

// File: rtl/free_list.sv
// Physical-register free list for 2-wide rename: speculative head for
// allocation, committed head for flush recovery, tail for commit releases.
module free_list
    import free_list_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_req_1,
    input  logic                   alloc_req_2,
    output logic                   alloc_ready,
    output logic [PHY_REG_SEL-1:0] phy_dst_1,
    output logic [PHY_REG_SEL-1:0] phy_dst_2,
    input  logic                   commit_alloc_1,
    input  logic                   commit_alloc_2,
    input  logic                   release_valid_1,
    input  logic                   release_valid_2,
    input  logic [PHY_REG_SEL-1:0] release_tag_1,
    input  logic [PHY_REG_SEL-1:0] release_tag_2,
    input  logic                   flush,
    output logic [FL_CNT_W-1:0]    free_count,
    output logic                   overflow_err
);

    localparam logic [FL_CNT_W:0] DEPTH_W = (FL_CNT_W + 1)'(FL_DEPTH);

    ptr_t spec_head_q, spec_head_d;
    ptr_t commit_head_q, commit_head_d;
    ptr_t tail_q, tail_d;
    logic overflow_q, overflow_d;

    logic [1:0] need, rel_cnt, cmt_cnt;
    cnt_t       free_cnt;
    ptr_t       in_flight;
    logic       alloc_fire, rel_ovf, cmt_ovf;

    logic we_0, we_1;
    idx_t waddr_0, waddr_1;
    tag_t wdata_0, wdata_1;
    tag_t rdata_0, rdata_1;

    free_list_storage u_storage (
        .clk       (clk),
        .reset     (reset),
        .raddr_0_i (ptr_idx(spec_head_q)),
        .raddr_1_i (ptr_idx(spec_head_q + ptr_t'(1))),
        .rdata_0_o (rdata_0),
        .rdata_1_o (rdata_1),
        .we_0_i    (we_0),
        .waddr_0_i (waddr_0),
        .wdata_0_i (wdata_0),
        .we_1_i    (we_1),
        .waddr_1_i (waddr_1),
        .wdata_1_i (wdata_1)
    );

    assign need      = pair_count(alloc_req_1, alloc_req_2);
    assign rel_cnt   = pair_count(release_valid_1, release_valid_2);
    assign cmt_cnt   = pair_count(commit_alloc_1, commit_alloc_2);
    assign free_cnt  = cnt_t'(tail_q - spec_head_q);
    assign in_flight = spec_head_q - commit_head_q;

    assign alloc_ready = !flush && (free_cnt >= {{(FL_CNT_W-2){1'b0}}, need});
    assign alloc_fire  = alloc_ready && (need != 2'd0);

    // Releases are checked against the speculative free count; commits must
    // never retire more allocations than are outstanding.
    assign rel_ovf = ({1'b0, free_cnt} + {{(FL_CNT_W-1){1'b0}}, rel_cnt}) > DEPTH_W;
    assign cmt_ovf = {{(FL_PTR_W-2){1'b0}}, cmt_cnt} > in_flight;

    always_comb begin
        spec_head_d   = spec_head_q;
        commit_head_d = commit_head_q + ptr_t'(cmt_cnt);
        tail_d        = tail_q;
        overflow_d    = overflow_q || rel_ovf || cmt_ovf;
        we_0          = 1'b0;
        we_1          = 1'b0;
        waddr_0       = ptr_idx(tail_q);
        waddr_1       = ptr_idx(tail_q + ptr_t'(1));
        wdata_0       = release_valid_1 ? release_tag_1 : release_tag_2;
        wdata_1       = release_tag_2;

        if (flush) begin
            spec_head_d = commit_head_q + ptr_t'(cmt_cnt);
        end else if (alloc_fire) begin
            spec_head_d = spec_head_q + ptr_t'(need);
        end

        if (!rel_ovf) begin
            tail_d = tail_q + ptr_t'(rel_cnt);
            we_0   = release_valid_1 || release_valid_2;
            we_1   = release_valid_1 && release_valid_2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= ptr_t'(FL_DEPTH);
            overflow_q    <= 1'b0;
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            overflow_q    <= overflow_d;
        end
    end

    assign phy_dst_1    = rdata_0;
    assign phy_dst_2    = alloc_req_1 ? rdata_1 : rdata_0;
    assign free_count   = free_cnt;
    assign overflow_err = overflow_q;

    // Tag 0 is permanently mapped and must never come back to the pool.
    a_no_tag0_rel_1: assert property (@(posedge clk) disable iff (!reset)
        release_valid_1 |-> release_tag_1 != '0);
    a_no_tag0_rel_2: assert property (@(posedge clk) disable iff (!reset)
        release_valid_2 |-> release_tag_2 != '0);

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: table of per-cycle vectors plus
// hand-written drain, stall, commit-overflow and wrap-around sequences.
module tb_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req_1, alloc_req_2, alloc_ready;
    logic [5:0] phy_dst_1, phy_dst_2;
    logic       commit_alloc_1, commit_alloc_2;
    logic       release_valid_1, release_valid_2;
    logic [5:0] release_tag_1, release_tag_2;
    logic       flush;
    logic [5:0] free_count;
    logic       overflow_err;

    int n_vec = 0;
    int n_err = 0;

    free_list dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req_1     (alloc_req_1),
        .alloc_req_2     (alloc_req_2),
        .alloc_ready     (alloc_ready),
        .phy_dst_1       (phy_dst_1),
        .phy_dst_2       (phy_dst_2),
        .commit_alloc_1  (commit_alloc_1),
        .commit_alloc_2  (commit_alloc_2),
        .release_valid_1 (release_valid_1),
        .release_valid_2 (release_valid_2),
        .release_tag_1   (release_tag_1),
        .release_tag_2   (release_tag_2),
        .flush           (flush),
        .free_count      (free_count),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rr;   // {alloc_req_1, alloc_req_2, release_valid_1, release_valid_2}
        logic [5:0] t1;
        logic [5:0] t2;
        logic [2:0] cf;   // {commit_alloc_1, commit_alloc_2, flush}
        logic       rdy;
        logic [5:0] p1;
        logic [5:0] p2;
        logic [5:0] fc;
        logic       ovf;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] rr, input logic [5:0] t1, input logic [5:0] t2,
                                input logic [2:0] cf, input logic rdy, input logic [5:0] p1,
                                input logic [5:0] p2, input logic [5:0] fc, input logic ovf);
        vec_t v;
        v.rr = rr; v.t1 = t1; v.t2 = t2; v.cf = cf;
        v.rdy = rdy; v.p1 = p1; v.p2 = p2; v.fc = fc; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic [3:0] rr, input logic [5:0] t1, input logic [5:0] t2,
                              input logic [2:0] cf);
        alloc_req_1     = rr[3];
        alloc_req_2     = rr[2];
        release_valid_1 = rr[1];
        release_valid_2 = rr[0];
        release_tag_1   = t1;
        release_tag_2   = t2;
        commit_alloc_1  = cf[2];
        commit_alloc_2  = cf[1];
        flush           = cf[0];
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [3:0] rr, input logic [5:0] t1, input logic [5:0] t2,
                         input logic [2:0] cf);
        @(negedge clk);
        set_inputs(rr, t1, t2, cf);
        #1;
    endtask

    task automatic do_reset();
        set_inputs(4'b0000, 6'd0, 6'd0, 3'b000);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs [14];
        vec_t       sb_q [$];
        vec_t       e;
        logic [5:0] tq [$];
        logic [5:0] et;

        //             rr       t1     t2     cf      rdy   p1     p2     fc     ovf
        vecs[0]  = mk(4'b1100, 6'd0,  6'd0,  3'b000, 1'b1, 6'd32, 6'd33, 6'd32, 1'b0);
        vecs[1]  = mk(4'b0000, 6'd0,  6'd0,  3'b000, 1'b1, 6'd34, 6'd34, 6'd30, 1'b0);
        vecs[2]  = mk(4'b0100, 6'd0,  6'd0,  3'b000, 1'b1, 6'd34, 6'd34, 6'd30, 1'b0);
        vecs[3]  = mk(4'b1000, 6'd0,  6'd0,  3'b000, 1'b1, 6'd35, 6'd36, 6'd29, 1'b0);
        vecs[4]  = mk(4'b1110, 6'd5,  6'd0,  3'b110, 1'b1, 6'd36, 6'd37, 6'd28, 1'b0);
        vecs[5]  = mk(4'b1000, 6'd0,  6'd0,  3'b101, 1'b0, 6'd38, 6'd39, 6'd27, 1'b0);
        vecs[6]  = mk(4'b0000, 6'd0,  6'd0,  3'b000, 1'b1, 6'd35, 6'd35, 6'd30, 1'b0);
        vecs[7]  = mk(4'b0101, 6'd0,  6'd9,  3'b000, 1'b1, 6'd35, 6'd35, 6'd30, 1'b0);
        vecs[8]  = mk(4'b0011, 6'd11, 6'd12, 3'b000, 1'b1, 6'd36, 6'd36, 6'd30, 1'b0);
        vecs[9]  = mk(4'b0000, 6'd0,  6'd0,  3'b000, 1'b1, 6'd36, 6'd36, 6'd32, 1'b0);
        vecs[10] = mk(4'b0010, 6'd3,  6'd0,  3'b000, 1'b1, 6'd36, 6'd36, 6'd32, 1'b0);
        vecs[11] = mk(4'b0000, 6'd0,  6'd0,  3'b000, 1'b1, 6'd36, 6'd36, 6'd32, 1'b1);
        vecs[12] = mk(4'b1100, 6'd0,  6'd0,  3'b000, 1'b1, 6'd36, 6'd37, 6'd32, 1'b1);
        vecs[13] = mk(4'b0000, 6'd0,  6'd0,  3'b000, 1'b1, 6'd38, 6'd38, 6'd30, 1'b1);

        do_reset();
        chk("reset.count", 32'(free_count), 32);
        chk("reset.ready", 32'(alloc_ready), 1);
        chk("reset.dst1",  32'(phy_dst_1), 32);
        chk("reset.ovf",   32'(overflow_err), 0);

        // Table: alloc pair/single, release, commit, flush, overflow.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_inputs(vecs[i].rr, vecs[i].t1, vecs[i].t2, vecs[i].cf);
            sb_q.push_back(vecs[i]);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("vec%0d.ready", i), 32'(alloc_ready), 32'(e.rdy));
            chk($sformatf("vec%0d.dst1", i),  32'(phy_dst_1),   32'(e.p1));
            chk($sformatf("vec%0d.dst2", i),  32'(phy_dst_2),   32'(e.p2));
            chk($sformatf("vec%0d.count", i), 32'(free_count),  32'(e.fc));
            chk($sformatf("vec%0d.ovf", i),   32'(overflow_err), 32'(e.ovf));
        end

        // Drain with single slot-2 requests down to empty, then stall.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            drive(4'b0100, 6'd0, 6'd0, 3'b000);
            chk("drain.ready", 32'(alloc_ready), 1);
            chk("drain.dst2",  32'(phy_dst_2), 32'(32 + k));
            chk("drain.count", 32'(free_count), 32'(32 - k));
        end
        repeat (2) begin
            drive(4'b0100, 6'd0, 6'd0, 3'b000);
            chk("empty.ready", 32'(alloc_ready), 0);
            chk("empty.count", 32'(free_count), 0);
            chk("empty.dst1",  32'(phy_dst_1), 32);
            chk("empty.dst2",  32'(phy_dst_2), 32);
        end

        // One free tag and a pair request: all-or-nothing stall, then grant.
        drive(4'b0010, 6'd40, 6'd0, 3'b000);
        chk("stall.count0", 32'(free_count), 0);
        drive(4'b1100, 6'd0, 6'd0, 3'b000);
        chk("stall.ready1", 32'(alloc_ready), 0);
        chk("stall.count1", 32'(free_count), 1);
        drive(4'b1110, 6'd5, 6'd0, 3'b000);
        chk("stall.ready2", 32'(alloc_ready), 0);
        chk("stall.count2", 32'(free_count), 1);
        drive(4'b1100, 6'd0, 6'd0, 3'b000);
        chk("grant.ready", 32'(alloc_ready), 1);
        chk("grant.count", 32'(free_count), 2);
        chk("grant.dst1",  32'(phy_dst_1), 40);
        chk("grant.dst2",  32'(phy_dst_2), 5);
        drive(4'b0000, 6'd0, 6'd0, 3'b000);
        chk("grant.after", 32'(free_count), 0);
        chk("grant.ovf",   32'(overflow_err), 0);

        // Commit with nothing outstanding sets the sticky flag; reset clears it.
        do_reset();
        drive(4'b0000, 6'd0, 6'd0, 3'b100);
        chk("cmtovf.before", 32'(overflow_err), 0);
        drive(4'b0000, 6'd0, 6'd0, 3'b000);
        chk("cmtovf.set", 32'(overflow_err), 1);
        drive(4'b0000, 6'd0, 6'd0, 3'b000);
        chk("cmtovf.sticky", 32'(overflow_err), 1);
        do_reset();
        chk("cmtovf.cleared", 32'(overflow_err), 0);

        // Wrap: tail reaches index 31, a pair release straddles the ring end.
        for (int k = 0; k < 16; k++) begin
            drive(4'b1100, 6'd0, 6'd0, 3'b000);
            chk("wrap.fill", 32'(alloc_ready), 1);
        end
        for (int k = 0; k < 31; k++) begin
            drive(4'b0010, 6'(k + 1), 6'd0, 3'b000);
            tq.push_back(6'(k + 1));
            chk("wrap.relcount", 32'(free_count), 32'(k));
        end
        drive(4'b1000, 6'd0, 6'd0, 3'b000);
        et = tq.pop_front();
        chk("wrap.first", 32'(phy_dst_1), 32'(et));
        chk("wrap.count31", 32'(free_count), 31);
        drive(4'b0011, 6'd7, 6'd9, 3'b000);
        tq.push_back(6'd7);
        tq.push_back(6'd9);
        chk("wrap.count30", 32'(free_count), 30);
        for (int k = 0; k < 32; k++) begin
            drive(4'b1000, 6'd0, 6'd0, 3'b000);
            if (tq.size() == 0) begin
                chk("wrap.queue", 0, 1);
            end else begin
                et = tq.pop_front();
                chk($sformatf("wrap.fifo%0d", k), 32'(phy_dst_1), 32'(et));
            end
            chk("wrap.count", 32'(free_count), 32'(32 - k));
        end
        drive(4'b0000, 6'd0, 6'd0, 3'b000);
        chk("wrap.empty", 32'(free_count), 0);
        chk("wrap.ovf",   32'(overflow_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
